// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - Q16.16 fixed-point types, pipeline latency and shared product rounding
package fixed_pkg;

  localparam int TOTAL_WIDTH = 32;
  localparam int FRAC_WIDTH  = 16;
  localparam int MUL_LATENCY = 3;

  typedef logic signed [TOTAL_WIDTH-1:0]   fixed;
  typedef logic signed [2*TOTAL_WIDTH-1:0] fixed_wide;

  localparam fixed_wide ROUND_HALF     = fixed_wide'(1) <<< (FRAC_WIDTH - 1);
  localparam fixed_wide FIXED_MAX_WIDE = (fixed_wide'(1) <<< (TOTAL_WIDTH - 1)) - fixed_wide'(1);
  localparam fixed_wide FIXED_MIN_WIDE = -(fixed_wide'(1) <<< (TOTAL_WIDTH - 1));

  // Round-half-up: ties move toward +inf because the shift floors.
  function automatic fixed_wide mul_round(input fixed_wide p);
    return (p + ROUND_HALF) >>> FRAC_WIDTH;
  endfunction

endpackage

// File: rtl/fixed_mul_pipe.sv
// rtl/fixed_mul_pipe.sv - three-stage tagged Q16.16 multiplier (operands, product, rounded result)
// Saturation and sticky overflow are built only with FIXED_MUL_SATURATE_EN defined.
module fixed_mul_pipe
  import fixed_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  fixed             a,
  input  fixed             b,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output fixed             out_result,
  output logic             overflow
);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  fixed             s1_a;
  fixed             s1_b;
  logic             s2_valid;
  logic [TAG_W-1:0] s2_tag;
  fixed_wide        s2_prod;
  fixed_wide        rounded;
  fixed             next_result;

`ifdef FIXED_MUL_SATURATE_EN
  logic next_ovf;

  always_comb begin
    rounded     = mul_round(s2_prod);
    next_result = fixed'(rounded);
    next_ovf    = 1'b0;
    if (rounded > FIXED_MAX_WIDE) begin
      next_result = fixed'(FIXED_MAX_WIDE);
      next_ovf    = 1'b1;
    end else if (rounded < FIXED_MIN_WIDE) begin
      next_result = fixed'(FIXED_MIN_WIDE);
      next_ovf    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (s2_valid && next_ovf) begin
      overflow <= 1'b1;
    end
  end
`else
  always_comb begin
    rounded     = mul_round(s2_prod);
    next_result = fixed'(rounded);
  end

  assign overflow = 1'b0;
`endif

  // Data registers only load behind a valid so out_result holds between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_tag     <= '0;
      s2_prod    <= '0;
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_result <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_tag <= in_tag;
        s1_a   <= a;
        s1_b   <= b;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag  <= s1_tag;
        s2_prod <= fixed_wide'(s1_a) * fixed_wide'(s1_b);
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_tag    <= s2_tag;
        out_result <= next_result;
      end
    end
  end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// rtl/fixed_mul_arbiter.sv - round-robin sharing of one fixed_mul_pipe among NUM_REQ requesters
// FIXED_MUL_SATURATE_EN selects saturating results with a sticky overflow flag.
module fixed_mul_arbiter
  import fixed_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][TOTAL_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][TOTAL_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic [TOTAL_WIDTH-1:0]                resp_result,
  output logic                                  busy,
  output logic                                  overflow
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]       last;
  logic [TAG_W-1:0]       cand;
  logic [TAG_W-1:0]       grant_idx;
  logic                   grant;
  logic                   out_valid;
  logic [TAG_W-1:0]       out_tag;
  fixed                   out_result;
  logic [MUL_LATENCY-1:0] in_flight;

  // First valid requester after the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (!reset) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = TAG_W'((int'(last) + k) % NUM_REQ);
        if (!grant && req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last      <= TAG_W'(NUM_REQ - 1);
      in_flight <= '0;
    end else begin
      if (grant) last <= grant_idx;
      // Shadow of the pipe's stage valids, one bit per stage.
      in_flight <= {in_flight[MUL_LATENCY-2:0], grant};
    end
  end

  fixed_mul_pipe #(.TAG_W(TAG_W)) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (grant),
    .in_tag     (grant_idx),
    .a          (fixed'(req_a[grant_idx])),
    .b          (fixed'(req_b[grant_idx])),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .out_result (out_result),
    .overflow   (overflow)
  );

  always_comb begin
    resp_valid = '0;
    if (out_valid) resp_valid[out_tag] = 1'b1;
  end

  assign resp_result = out_result;
  assign busy        = |in_flight;

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// tb/tb_fixed_mul_arbiter.sv - vector table, directed corner sequences and randomized traffic vs reference model
module tb_fixed_mul_arbiter;

`ifdef FIXED_MUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_a;
  logic [3:0][31:0] req_b;
  logic [3:0]       resp_valid;
  logic [31:0]      resp_result;
  logic             busy;
  logic             overflow;

  fixed_mul_arbiter #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        ovf;
    int          due;
  } op_t;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  op_t         inflight[$];
  int          grant_log[$];
  int          resp_cnt[4];
  int          cyc;
  int          m_last;
  int          m_grant;
  logic [31:0] m_result;
  logic        m_ovf;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Exact product, round half up, then saturate or wrap to 32 bits.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ovf);
    longint p;
    longint q;
    p = longint'(signed'(a)) * longint'(signed'(b));
    q = (p + 64'sd32768) >>> 16;
    ovf = 1'b0;
    r   = q[31:0];
    if (SAT && q > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      ovf = 1'b1;
    end else if (SAT && q < -64'sd2147483648) begin
      r = 32'h8000_0000;
      ovf = 1'b1;
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One clock: inputs already driven at the negedge; check, then advance the model.
  task automatic cycle();
    logic [3:0]  exp_ready;
    logic [3:0]  exp_resp;
    logic [31:0] r;
    logic        o;
    #1;
    if (reset) begin
      inflight.delete();
      m_last   = 3;
      m_result = '0;
      m_ovf    = 1'b0;
    end
    m_grant   = reset ? -1 : pick(req_valid, m_last);
    exp_ready = (m_grant >= 0) ? 4'(1 << m_grant) : 4'd0;
    exp_resp  = '0;
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      exp_resp = 4'(1 << inflight[0].idx);
      m_result = inflight[0].res;
      m_ovf    = m_ovf | inflight[0].ovf;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("resp_valid", 64'(resp_valid), 64'(exp_resp));
    check("resp_result", 64'(resp_result), 64'(m_result));
    check("busy", 64'(busy), 64'(inflight.size() > 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i] === 1'b1) grant_log.push_back(i);
      if (resp_valid[i] === 1'b1) resp_cnt[i]++;
    end
    r = '0;
    o = 1'b0;
    if (m_grant >= 0) ref_mul(req_a[m_grant[1:0]], req_b[m_grant[1:0]], r, o);
    @(posedge clk);
    if (exp_resp != 0) void'(inflight.pop_front());
    if (m_grant >= 0) begin
      inflight.push_back('{idx: m_grant, res: r, ovf: o, due: cyc + 3});
      m_last = m_grant;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_one(input int r, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] got, output int busy_cnt);
    req_valid    = 4'(1 << r);
    req_a[r[1:0]] = a;
    req_b[r[1:0]] = b;
    cycle();
    req_valid = '0;
    got       = 32'hDEAD_BEEF;
    busy_cnt  = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (resp_valid[r[1:0]] === 1'b1) got = resp_result;
      cycle();
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] edges[6];
    int          v;
    edges = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_8000, 32'hFFFF_8000, 32'h0000_0001, 32'hFFFF_FFFF};
    case ($urandom_range(2, 0))
      0: return $urandom;
      1: begin
        v = int'($urandom_range(0, 262143)) - 131072;
        return v;
      end
      default: return edges[$urandom_range(5, 0)];
    endcase
  endfunction

  vec_t        vecs[9];
  logic [31:0] got;
  int          bcnt;
  int          base[4];
  int          total_before;
  int          total_after;
  int          accepted;
  logic [3:0]  pend;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_last    = 3;
    m_result  = '0;
    m_ovf     = 1'b0;
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < 4; i++) resp_cnt[i] = 0;

    vecs[0] = '{0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000};
    vecs[1] = '{1, 32'h0000_0001, 32'h0000_8000, 32'h0000_0001};
    vecs[2] = '{2, 32'h0000_0001, 32'h0000_7FFF, 32'h0000_0000};
    vecs[3] = '{3, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000};
    vecs[4] = '{0, 32'hFFFF_8000, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{1, 32'hFFFF_FFFF, 32'h0000_8001, 32'hFFFF_FFFF};
    vecs[6] = '{2, 32'hFFFE_0000, 32'hFFFD_0000, 32'h0006_0000};
    vecs[7] = '{3, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[8] = '{0, 32'h0100_0000, 32'h0100_0000, SAT ? 32'h7FFF_FFFF : 32'h0000_0000};

    @(negedge clk);
    do_reset();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(resp_result), 64'd0);

    for (int v = 0; v < 9; v++) begin
      run_one(vecs[v].r, vecs[v].a, vecs[v].b, got, bcnt);
      check($sformatf("vec%0d_result", v), 64'(got), 64'(vecs[v].exp));
      check($sformatf("vec%0d_busy_cycles", v), 64'(bcnt), 64'd3);
    end
    check("overflow_sticky", 64'(overflow), 64'(SAT));
    cycle();
    check("overflow_still_set", 64'(overflow), 64'(SAT));
    do_reset();
    check("overflow_after_reset", 64'(overflow), 64'd0);

    // Fairness: all four hold valid for 8 cycles.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      base[i] = resp_cnt[i];
      req_a[i] = rnd_op();
      req_b[i] = rnd_op();
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (m_grant >= 0) begin
        req_a[m_grant[1:0]] = rnd_op();
        req_b[m_grant[1:0]] = rnd_op();
      end
    end
    req_valid = '0;
    for (int k = 0; k < 5; k++) cycle();
    check("fair_grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check($sformatf("fair_grant%0d", k), 64'(grant_log[k]), 64'(k % 4));
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_resp_count%0d", i), 64'(resp_cnt[i] - base[i]), 64'd2);

    // Priority after idle: 2 alone, then 1 and 3 together.
    grant_log.delete();
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    req_valid = 4'b1010;
    cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    for (int k = 0; k < 5; k++) cycle();
    check("prio_grant_count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
      check("prio_first", 64'(grant_log[0]), 64'd2);
      check("prio_second", 64'(grant_log[1]), 64'd3);
      check("prio_third", 64'(grant_log[2]), 64'd1);
    end

    // Reset one cycle after two accepts: nothing comes out.
    total_before = resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3];
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'hF;
    reset     = 1'b1;
    cycle();
    check("rst_ready_zero", 64'(req_ready), 64'd0);
    check("rst_busy_zero", 64'(busy), 64'd0);
    cycle();
    reset     = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 6; k++) cycle();
    total_after = resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3];
    check("rst_no_resp", 64'(total_after - total_before), 64'd0);
    grant_log.delete();
    req_valid = 4'b1001;
    cycle();
    req_valid = '0;
    check("rst_next_grant_count", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() == 1) check("rst_next_grant", 64'(grant_log[0]), 64'd0);
    for (int k = 0; k < 5; k++) cycle();

    // Randomized traffic, every cycle checked against the model.
    total_before = resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3];
    accepted = 0;
    pend = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i]  = 1'b1;
          req_a[i] = rnd_op();
          req_b[i] = rnd_op();
        end
      end
      req_valid = pend;
      cycle();
      if (m_grant >= 0) begin
        pend[m_grant[1:0]] = 1'b0;
        accepted++;
      end
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) cycle();
    total_after = resp_cnt[0] + resp_cnt[1] + resp_cnt[2] + resp_cnt[3];
    check("rand_resp_total", 64'(total_after - total_before), 64'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_mul_arbiter.md
# fixed_mul_arbiter

Shares one pipelined fixed-point multiplier between `NUM_REQ` requesters, e.g. transform, shading and rasteriser stages. A round-robin arbiter accepts at most one operand pair per cycle, and each product returns to its originator after a fixed latency. Products are rounded to nearest rather than truncated. The block sits between the math consumers and the single hard multiplier resource.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `clk`  in  1: system clock, all logic rising-edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `req_valid`  in  NUM_REQ: requester i has an operand pair.
- `req_ready`  out  NUM_REQ: one-hot or zero; the pair from i is accepted this cycle.
- `req_a`  in  NUM_REQ x fixed: left operands, Q16.16 signed.
- `req_b`  in  NUM_REQ x fixed: right operands.
- `resp_valid`  out  NUM_REQ: one-hot or zero, single-cycle result strobe.
- `resp_result`  out  fixed: shared result bus, valid when any `resp_valid` is high.
- `busy`  out  1: at least one operation is in flight.
- `overflow`  out  1: sticky overflow flag. Present only with the macro; otherwise tied 0.

## Operation
- **Grant:**
  - `req_ready[g]` = 1 for the first i with `req_valid[i]`, searching from `last+1` and wrapping modulo NUM_REQ.
  - `req_ready` is combinational from `req_valid` and `last`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer:** `last` updates to g only on a grant and holds otherwise.
- **Operands:** a requester must hold `req_valid`, `req_a` and `req_b` stable until ready.
- **Result:**
  - Product p = a*b, computed 64-bit signed.
  - Result = (p + 0x8000) >>> 16, truncated to 32 bits. Ties round toward +inf.
- **Tagging:** each pipeline stage carries valid and a requester index of `$clog2(NUM_REQ)` bits.
- **Output stage:** decodes the index into one-hot `resp_valid`.
- **No response backpressure:** requesters must accept a result in its strobe cycle.
- **Throughput:** 1 op/cycle sustained. Requesters holding `req_valid` continuously with all requesters active are granted in strict rotation 0,1,…,NUM_REQ-1,0.
- **busy:** OR of the stage valids.

## Timing
- Latency is 3 cycles: accept at edge N, `resp_valid` high during cycle N+3.
- Pipeline stages:
  - Stage 1 registers operands and tag.
  - Stage 2 registers the 64-bit product.
  - Stage 3 registers the rounded and optionally saturated result.
- **Reset values:**
  - `resp_valid` = 0, `resp_result` = 0, `busy` = 0, `overflow` = 0.
  - All stage valids = 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
- **Reset mid-operation:** in-flight ops are discarded and no response is issued. `req_ready` = 0 while reset is asserted.
- **Simultaneous events:** accept and result delivery in the same cycle are independent and both occur.
- **resp_result:** holds its last value when `resp_valid` = 0.

## Configuration
- Macro: `FIXED_MUL_SATURATE_EN`.
- **Defined:**
  - The stage-3 input is the rounded 64-bit value after `>>> 16`.
  - If it exceeds 32'h7FFFFFFF, the output is 32'h7FFFFFFF; if below 32'h80000000, the output is 32'h80000000.
  - `overflow` sets on either condition and clears only on reset.
- **Undefined:**
  - The result wraps by taking the low 32 bits.
  - No compare logic is built and `overflow` = 0.

## Structure
- Add to `fixed_pkg`:
  - `typedef logic signed [2*TOTAL_WIDTH-1:0] fixed_wide`.
  - `localparam int MUL_LATENCY = 3`.
  - Function `mul_round(fixed_wide p)` returning the rounded 64-bit value, shared with any future rounding users.
- Sub-module `fixed_mul_pipe` holds stages 1–3 and the saturation. Its ports are `clk`, `reset`, `in_valid`, `in_tag`, `a`, `b`, `out_valid`, `out_tag`, `out_result` and `overflow`.
- The top level holds the round-robin arbiter, operand mux and tag decode.

## Test plan
- **Basic product:** requester 0 sends 1.5 × 2.0 (0x00018000, 0x00020000). Expect `resp_valid[0]` 3 cycles later with 0x00030000, and `busy` high for exactly 3 cycles.
- **Rounding and sign:**
  - 0x00000001 × 0x00008000 → 0x00000001.
  - 0x00000001 × 0x00007FFF → 0x00000000.
  - −1.5 × 2.0 → 0xFFFD0000.
- **Fairness:** all 4 requesters hold valid for 8 cycles. Grants go 0,1,2,3,0,1,2,3 and each requester receives 2 results with correct tags in grant order.
- **Overflow:** 256.0 × 256.0 (0x01000000 squared).
  - With the macro: 0x7FFFFFFF and `overflow` = 1 until reset.
  - Without the macro: 0x00000000.
- **Priority after idle:** requester 2 is granted alone, then requesters 1 and 3 request together. Requester 3 is granted first, then requester 1.
- **Reset mid-operation:** assert reset 1 cycle after two accepts. No `resp_valid` ever appears, `busy` = 0, and the next grant goes to requester 0.
